// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial multiplier host.
//   W_DEFAULT    : default operand width
//   host_state_t : host FSM states
//   cnt_w()      : width of a counter that must reach 2W
package bit_serial_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } host_state_t;

  // Counter width able to hold the value 2*w.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/bit_serial_deser.sv
// Right-shift serial-to-parallel collector.
// Each enabled cycle the incoming bit enters at the MSB and the register shifts
// right, so the first bit taken ends up at bit 0 after Width enabled cycles.
//   clk    : clock
//   rst    : asynchronous active-high reset (clears data)
//   clr    : synchronous clear, has priority over en
//   en     : take bit_in this cycle
//   bit_in : serial input bit
//   data   : collected parallel word
module bit_serial_deser #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [Width-1:0] data
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= {bit_in, data_q[Width-1:1]};
    end
  end

  assign data = data_q;

endmodule

// File: rtl/bit_serial_mul_host.sv
// Initiator-side adapter for a bit-serial multiplier.
// Accepts a parallel operand pair, streams x to the multiplier LSB first,
// collects the serial product into 2W bits and returns it over valid/ready.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_a, in_x operands
//   out_valid/out_ready  : product handshake; out_p = in_a * in_x (2W bits)
//   busy                 : high while an operation is in RUN or DONE
//   mul_a                : parallel multiplicand to the multiplier
//   mul_x_bit            : serial multiplier bit to the multiplier, LSB first
//   mul_y                : serial product bit from the multiplier, LSB first
module bit_serial_mul_host
  import bit_serial_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy,
  output logic [W-1:0]   mul_a,
  output logic           mul_x_bit,
  input  logic           mul_y
);

  localparam int unsigned CW = cnt_w(W);
  localparam logic [CW-1:0] CntLast = CW'(2 * W);

  host_state_t    state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   xsh_q;
  logic [W-1:0]   a_q;
  logic [2*W-1:0] psh;
  logic           accept;
  logic           capture;

  assign accept = (state_q == IDLE) && in_valid;
  // mul_y carries product bit k-1 during cnt=k, so nothing useful arrives at cnt=0.
  assign capture = (state_q == RUN) && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xsh_q   <= '0;
      a_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            xsh_q   <= in_x;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Zero fill keeps feeding 0s once x is used up, flushing the multiplier.
          xsh_q <= {1'b0, xsh_q[W-1:1]};
          if (cnt_q == CntLast) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bit_serial_deser #(
    .Width(2 * W)
  ) u_psh (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (capture),
    .bit_in(mul_y),
    .data  (psh)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_p     = psh;
  assign busy      = (state_q != IDLE);
  assign mul_a     = a_q;
  assign mul_x_bit = ((state_q == RUN) && (cnt_q < CntLast)) ? xsh_q[0] : 1'b0;

endmodule
